// File: rtl/flac_pkg.sv
// Shared FLAC decoder types: frame sequencer state encoding and default widths.
// Pure declarations; no logic, no timing.
package flac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int NCH_W_DEF    = 3;
    localparam int BS_W_DEF     = 16;
    localparam int ADDR_W_DEF   = 16;
    localparam int SETUP_CYCLES = 2;

endpackage

// File: rtl/frame_sequencer.sv
// Walks one FLAC frame through the subframe decoder channel by channel, forwarding tagged samples.
// Sample out one cycle after iSfDone; no back-pressure (the decoder paces everything).
module frame_sequencer
    import flac_pkg::*;
#(
    parameter int NCH_W  = NCH_W_DEF,
    parameter int BS_W   = BS_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic [NCH_W-1:0]         iNChannels,
    input  logic [BS_W-1:0]          iBlockSize,
    input  logic [ADDR_W-1:0]        iFrameAddr,
    input  logic                     iAbort,
    output logic                     oSfReset,
    output logic                     oSfEnable,
    output logic [BS_W-1:0]          oSfNSamples,
    output logic [ADDR_W-1:0]        oSfStartAddr,
    input  logic                     iSfDone,
    input  logic signed [15:0]       iSfSample,
    input  logic [ADDR_W-1:0]        iSfEndAddr,
    output logic signed [15:0]       oSample,
    output logic                     oSampleValid,
    output logic [NCH_W-1:0]         oChannel,
    output logic                     oFrameDone,
    output logic                     oBusy,
    output logic                     oError
);

    localparam logic TMR_LAST = 1'(SETUP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             tmr;
    logic [NCH_W-1:0] nch;
    logic [NCH_W-1:0] chan;
    logic [BS_W-1:0]  bs;
    logic [BS_W-1:0]  cnt;
    logic             last_smp;
    logic             accept;

    // count is compared before it is incremented, so it never needs to reach bs
    assign last_smp    = (cnt == bs - BS_W'(1));
    assign accept      = (state == S_RUN) && iSfDone && !iAbort;
    assign oBusy       = (state != S_IDLE);
    assign oSfNSamples = bs;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        oSfReset   = 1'b1;
        oSfEnable  = 1'b0;
        oFrameDone = 1'b0;
        case (state)
            S_IDLE: begin
                if (iStart && (iBlockSize != '0)) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (tmr == TMR_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                oSfReset  = 1'b0;
                oSfEnable = 1'b1;
                if (iSfDone && last_smp) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = (chan == nch) ? S_DONE : S_SETUP;
            end
            S_DONE: begin
                oFrameDone = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if ((state != S_IDLE) && iAbort) begin
            state_nxt  = S_IDLE;
            oFrameDone = 1'b0;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            tmr          <= 1'b0;
            nch          <= '0;
            chan         <= '0;
            bs           <= '0;
            cnt          <= '0;
            oSfStartAddr <= '0;
            oSample      <= '0;
            oSampleValid <= 1'b0;
            oChannel     <= '0;
            oError       <= 1'b0;
        end else begin
            oSampleValid <= 1'b0;
            oError       <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmr <= 1'b0;
                    if (iStart) begin
                        if (iBlockSize == '0) begin
                            oError <= 1'b1;
                        end else begin
                            nch          <= iNChannels;
                            bs           <= iBlockSize;
                            oSfStartAddr <= iFrameAddr;
                            chan         <= '0;
                            cnt          <= '0;
                        end
                    end
                end
                S_SETUP: begin
                    tmr <= (tmr == TMR_LAST) ? 1'b0 : tmr + 1'b1;
                end
                S_RUN: begin
                    if (accept) begin
                        cnt          <= cnt + BS_W'(1);
                        oSample      <= iSfSample;
                        oChannel     <= chan;
                        oSampleValid <= 1'b1;
                        // next channel's subframe starts where this one ended
                        if (last_smp) oSfStartAddr <= iSfEndAddr;
                    end
                end
                S_NEXT: begin
                    cnt <= '0;
                    tmr <= 1'b0;
                    if (!iAbort && (chan != nch)) chan <= chan + NCH_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
